// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush control for load-use, taken branches and multi-cycle data memory access
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        idex_memRead,
  input  logic [4:0]  idex_rt,
  input  logic [2:0]  exmem_MEM,
  input  logic        exmem_zero,
  input  logic        dmem_ack,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        exmem_flush,
  output logic        pc_src,
  output logic        dmem_req,
  output logic        err,
  output logic [15:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  state_t      state_q, state_d;
  logic        mem_done_q, mem_done_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        err_q, err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        run, mem_stall, br_take, lu;
  always_comb begin
    run       = reset_n && state_q == RUN;
    mem_stall = run && (exmem_MEM[1] || exmem_MEM[0]) && !mem_done_q;
    br_take   = run && !mem_stall && exmem_MEM[2] && exmem_zero;
    lu        = run && !mem_stall && !br_take && idex_memRead && idex_rt != 5'd0 &&
                (idex_rt == id_rs || idex_rt == id_rt);
    exmem_en    = run && !mem_stall;
    pc_en       = exmem_en && !lu;
    ifid_en     = pc_en;
    ifid_flush  = br_take;
    idex_flush  = br_take || lu;
    exmem_flush = br_take;
    pc_src      = br_take;
    dmem_req    = state_q == MEM_WAIT;
    err         = err_q;
    stall_cnt   = stall_cnt_q;
  end
  always_comb begin
    state_d     = state_q;
    mem_done_d  = mem_done_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    stall_cnt_d = (!pc_en && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    if (state_q == RUN) begin
      mem_done_d = 1'b0;
      state_d    = mem_stall ? MEM_WAIT : RUN;
      wcnt_d     = mem_stall ? 4'd0 : wcnt_q;
    end else if (state_q == MEM_WAIT) begin
      if (dmem_ack) begin
        state_d    = RUN;
        mem_done_d = 1'b1;
      end else if (wcnt_q == 4'(TIMEOUT - 1)) begin
        state_d = ERROR;
        err_d   = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 4'd1;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      mem_done_q  <= 1'b0;
      wcnt_q      <= 4'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      mem_done_q  <= mem_done_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs, id_rt, idex_rt;
  logic        idex_memRead, exmem_zero, dmem_ack;
  logic [2:0]  exmem_MEM;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, exmem_flush, pc_src, dmem_req, err;
  logic [15:0] stall_cnt;

  // control vector order: pc_en ifid_en ifid_flush idex_flush exmem_en exmem_flush pc_src dmem_req err
  localparam logic [8:0] RST  = 9'b000000000;
  localparam logic [8:0] DEF  = 9'b110010000;
  localparam logic [8:0] LU   = 9'b000110000;
  localparam logic [8:0] BR   = 9'b111111100;
  localparam logic [8:0] MEMS = 9'b000000000;
  localparam logic [8:0] WT   = 9'b000000010;
  localparam logic [8:0] ERRS = 9'b000000001;

  typedef struct {
    string       tag;
    logic [8:0]  ctl;
    logic [15:0] st;
  } exp_t;
  exp_t q[$];

  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_stall = 16'd0;

  pipe_hazard_ctrl #(.TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .idex_memRead(idex_memRead), .idex_rt(idex_rt), .exmem_MEM(exmem_MEM),
    .exmem_zero(exmem_zero), .dmem_ack(dmem_ack), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .pc_src(pc_src), .dmem_req(dmem_req), .err(err),
    .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic step(input string tag, input logic [8:0] ctl);
    exp_t e;
    logic [8:0] got;
    if (!reset_n) exp_stall = 16'd0;
    q.push_back('{tag, ctl, exp_stall});
    @(negedge clock);
    e = q.pop_front();
    got = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, exmem_flush, pc_src, dmem_req, err};
    compared++;
    assert (got === e.ctl && stall_cnt === e.st) else begin
      mismatched++;
      $error("FAIL %s: got ctl=%b stall=%0d, expected ctl=%b stall=%0d", e.tag, got, stall_cnt, e.ctl, e.st);
    end
    if (reset_n && !ctl[8] && exp_stall != 16'hFFFF) exp_stall++;
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    id_rs = 0; id_rt = 0; idex_rt = 0; idex_memRead = 0;
    exmem_MEM = 0; exmem_zero = 0; dmem_ack = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    clr();
    step("rst0", RST);
    step("rst1", RST);
    reset_n = 1'b1;
    step("idle", DEF);
    idex_memRead = 1; idex_rt = 5; id_rs = 5;
    step("lu_rs", LU);
    id_rs = 0; id_rt = 5;
    step("lu_rt", LU);
    idex_rt = 0; id_rt = 0;
    step("lu_r0", DEF);
    idex_rt = 5; id_rs = 6; id_rt = 7;
    step("lu_nomatch", DEF);
    idex_memRead = 0; id_rs = 5;
    step("lu_noload", DEF);
    clr(); exmem_MEM = 3'b100; exmem_zero = 1;
    step("br_taken", BR);
    exmem_zero = 0;
    step("br_nottaken", DEF);
    exmem_zero = 1; idex_memRead = 1; idex_rt = 5; id_rs = 5;
    step("br_over_lu", BR);
    clr(); dmem_ack = 1;
    step("ack_ignored", DEF);
    clr(); exmem_MEM = 3'b010;
    step("mem_run", MEMS);
    step("mem_w1", WT);
    step("mem_w2", WT);
    dmem_ack = 1;
    step("mem_w3", WT);
    dmem_ack = 0;
    step("mem_adv", DEF);
    clr();
    step("mem_after", DEF);
    exmem_MEM = 3'b001; idex_memRead = 1; idex_rt = 5; id_rt = 5;
    step("sim_run", MEMS);
    dmem_ack = 1;
    step("sim_w1", WT);
    dmem_ack = 0;
    step("sim_adv_lu", LU);
    clr(); exmem_MEM = 3'b001;
    step("to_run", MEMS);
    for (int i = 0; i < 15; i++) step($sformatf("to_w%0d", i + 1), WT);
    step("to_err", ERRS);
    exmem_MEM = 0; dmem_ack = 1;
    step("err_hold", ERRS);
    #2 reset_n = 1'b0;
    step("err_rst", RST);
    reset_n = 1'b1; clr();
    step("err_rel", DEF);
    exmem_MEM = 3'b010;
    step("ab_run", MEMS);
    step("ab_w1", WT);
    #2 reset_n = 1'b0;
    step("ab_rst", RST);
    reset_n = 1'b1; clr();
    step("ab_rel", DEF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; ports SHALL be, in order:
  clock          in   1   rising-edge clock shared with all pipeline registers
  reset_n        in   1   asynchronous active-low reset
  id_rs          in   5   rs field of instruction in IF/ID
  id_rt          in   5   rt field of instruction in IF/ID
  idex_memRead   in   1   MEM read bit of instruction in ID/EX
  idex_rt        in   5   destination rt of instruction in ID/EX
  exmem_MEM      in   3   EX/MEM MEM control: [2] branch, [1] memRead, [0] memWrite
  exmem_zero     in   1   EX/MEM zero flag
  dmem_ack       in   1   data memory completion, valid only while dmem_req=1
  pc_en          out  1   PC load enable
  ifid_en        out  1   IF/ID load enable
  ifid_flush     out  1   IF/ID clear to NOP
  idex_flush     out  1   ID/EX control fields cleared (WB, MEM, EX = 0)
  exmem_en       out  1   EX/MEM and MEM/WB load enable
  exmem_flush    out  1   EX/MEM control fields cleared
  pc_src         out  1   select branch target (EX/MEM addPc) for PC
  dmem_req       out  1   data memory access request
  err            out  1   sticky memory-timeout error
  stall_cnt      out  16  saturating count of cycles with pc_en=0
REQ-002 Parameter: TIMEOUT, default 15, max MEM_WAIT cycles before error.

Function
REQ-003 The block SHALL implement FSM states RUN, MEM_WAIT, ERROR, plus a 1-bit flag mem_done and a 4-bit wait counter wcnt.
REQ-004 Outputs other than stall_cnt, err and dmem_req SHALL be combinational from state, flag and inputs; dmem_req SHALL be 1 iff state=MEM_WAIT.
REQ-005 Defaults (no condition active): pc_en=ifid_en=exmem_en=1, all flushes=0, pc_src=0.
REQ-006 Priority in RUN, highest first: memory access, taken branch, load-use.
REQ-007 Memory access: in RUN with (exmem_MEM[1]|exmem_MEM[0])=1 and mem_done=0 -> pc_en=ifid_en=exmem_en=0, no flushes; next state MEM_WAIT, wcnt<=0.
REQ-008 MEM_WAIT: pc_en=ifid_en=exmem_en=0; dmem_ack=1 -> next RUN, mem_done<=1; else wcnt<=wcnt+1.
REQ-009 MEM_WAIT with dmem_ack=0 and wcnt=TIMEOUT-1 -> next ERROR, err<=1.
REQ-010 mem_done SHALL clear on any clock edge where exmem_en=1 in RUN (EX/MEM advances); a done access SHALL NOT retrigger REQ-007.
REQ-011 Taken branch: in RUN, no REQ-007 condition, exmem_MEM[2]=1 and exmem_zero=1 -> pc_src=1, ifid_flush=idex_flush=exmem_flush=1, all enables 1; single cycle.
REQ-012 Load-use: in RUN, no higher condition, idex_memRead=1, idex_rt!=0, idex_rt equals id_rs or id_rt -> pc_en=ifid_en=0, idex_flush=1, exmem_en=1.
REQ-013 ERROR: all enables 0, flushes 0, pc_src=0; state held until reset.
REQ-014 stall_cnt SHALL increment each clock edge with pc_en=0 and saturate at 16'hFFFF, never wrapping.
REQ-015 dmem_ack outside MEM_WAIT SHALL be ignored.
REQ-016 Latency: memory op costs 1 RUN cycle + N MEM_WAIT cycles (N>=1, ack on Nth), then advances on the next RUN cycle.

Reset
REQ-017 reset_n=0 SHALL immediately force state=RUN, mem_done=0, wcnt=0, err=0, stall_cnt=0, dmem_req=0.
REQ-018 While reset_n=0, pc_en=ifid_en=exmem_en=0, all flushes=0, pc_src=0.
REQ-019 Reset asserted in MEM_WAIT or ERROR SHALL abandon the access; after release the block SHALL be in RUN with no pending request.
REQ-020 Reset deassertion SHALL take effect on the first rising clock edge after release.

Verification
REQ-021 Load-use: idex_memRead=1, idex_rt=5, id_rs=5, exmem_MEM=0 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1 for that cycle; stall_cnt +1.
REQ-022 Load-use on $0: idex_memRead=1, idex_rt=0, id_rt=0 -> no stall, defaults.
REQ-023 Memory op: exmem_MEM=3'b010, dmem_ack high on 3rd MEM_WAIT cycle -> dmem_req high 3 cycles, enables low 4 cycles, then exmem_en=1 one cycle; stall_cnt=4; no retrigger.
REQ-024 Branch: exmem_MEM=3'b100, exmem_zero=1 -> pc_src=1, three flushes=1 same cycle; exmem_zero=0 -> defaults.
REQ-025 Timeout: exmem_MEM=3'b001, dmem_ack held 0 -> after 15 MEM_WAIT cycles err=1, ERROR held; reset_n pulse -> RUN, err=0, stall_cnt=0.
REQ-026 Simultaneous: memory op in EX/MEM and load-use hazard -> REQ-007 response only (idex_flush=0).
